proc_step_ctrl: RTL and testbench

//  Consumes the slow square wave from the clock divider and turns it into single-cycle

---
 rtl/proc_ctrl_pkg.sv | 14 +
 rtl/sync_debounce.sv | 45 ++++
 rtl/proc_step_ctrl.sv | 106 ++++++++++
 tb/tb_proc_step_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_ctrl_pkg.sv
// Shared step-controller definitions: FSM state encodings and
// the debounce default, also used by the processor top for debug LEDs.
package proc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STEP_ARM = 2'd2,
        CPU_HALT = 2'd3
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser, debounce counter and one-cycle rising-edge
// pulse for a raw mechanical input.
module sync_debounce #(
    parameter int CYCLES = 500000,
    parameter int CW     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    logic          s1;
    logic          s2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // Counter only advances while the synced input disagrees with
    // the debounced level; any agreement restarts the stability window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            s1      <= raw;
            s2      <= s1;
            level_d <= level;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(CYCLES - 1)) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/proc_step_ctrl.sv
// Turns the divider's slow square wave into single-cycle step enables
// with free-run, halt and debounced single-step modes.
module proc_step_ctrl
    import proc_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int DB_W            = 20,
    parameter int STEP_W          = 16
) (
    input  logic              clkIn,
    input  logic              rst,
    input  logic              slowClk,
    input  logic              runSw,
    input  logic              stepBtn,
    input  logic              haltReq,
    output logic              stepEn,
    output logic              running,
    output logic              halted,
    output logic [STEP_W-1:0] stepCount
);

    logic   slow_s1;
    logic   slow_s2;
    logic   slow_d;
    logic   tick;
    logic   run_s1;
    logic   run_s2;
    logic   step_req;
    state_t state;
    state_t state_nx;
    logic   en_nx;

    sync_debounce #(
        .CYCLES (DEBOUNCE_CYCLES),
        .CW     (DB_W)
    ) u_btn (
        .clk  (clkIn),
        .rst  (rst),
        .raw  (stepBtn),
        .rise (step_req)
    );

    // tick is registered so a slowClk rise reaches stepEn in 4 edges
    always_ff @(posedge clkIn or posedge rst) begin
        if (rst) begin
            slow_s1 <= 1'b0;
            slow_s2 <= 1'b0;
            slow_d  <= 1'b0;
            tick    <= 1'b0;
            run_s1  <= 1'b0;
            run_s2  <= 1'b0;
        end else begin
            slow_s1 <= slowClk;
            slow_s2 <= slow_s1;
            slow_d  <= slow_s2;
            tick    <= slow_s2 & ~slow_d;
            run_s1  <= runSw;
            run_s2  <= run_s1;
        end
    end

    always_comb begin
        state_nx = state;
        en_nx    = 1'b0;
        unique case (state)
            IDLE: begin
                if (haltReq)       state_nx = CPU_HALT;
                else if (run_s2)   state_nx = RUN;
                else if (step_req) state_nx = STEP_ARM;
            end
            RUN: begin
                if (haltReq)      state_nx = CPU_HALT;
                else if (!run_s2) state_nx = IDLE;
                else if (tick)    en_nx    = 1'b1;
            end
            STEP_ARM: begin
                if (haltReq) begin
                    state_nx = CPU_HALT;
                end else if (tick) begin
                    en_nx    = 1'b1;
                    state_nx = IDLE;
                end
            end
            CPU_HALT: begin
                if (!run_s2 && step_req) state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clkIn or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            stepEn    <= 1'b0;
            running   <= 1'b0;
            halted    <= 1'b0;
            stepCount <= '0;
        end else begin
            state   <= state_nx;
            stepEn  <= en_nx;
            running <= (state_nx == RUN);
            halted  <= (state_nx == CPU_HALT);
            if (en_nx) stepCount <= stepCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_proc_step_ctrl.sv
// Bench for proc_step_ctrl: phase table, hand-written corner sequences
// and random stimulus, all checked against a cycle-level reference model.
module tb_proc_step_ctrl;

    localparam int C    = 4;
    localparam int SW   = 4;
    localparam int PER  = 20;
    localparam int MAXC = 16384;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_ARM  = 2;
    localparam int M_HALT = 3;

    logic          clkIn   = 1'b0;
    logic          rst     = 1'b1;
    logic          slowClk = 1'b0;
    logic          runSw   = 1'b0;
    logic          stepBtn = 1'b0;
    logic          haltReq = 1'b0;
    logic          stepEn;
    logic          running;
    logic          halted;
    logic [SW-1:0] stepCount;

    always #5 clkIn = ~clkIn;

    proc_step_ctrl #(
        .DEBOUNCE_CYCLES (C),
        .DB_W            (4),
        .STEP_W          (SW)
    ) dut (
        .clkIn     (clkIn),
        .rst       (rst),
        .slowClk   (slowClk),
        .runSw     (runSw),
        .stepBtn   (stepBtn),
        .haltReq   (haltReq),
        .stepEn    (stepEn),
        .running   (running),
        .halted    (halted),
        .stepCount (stepCount)
    );

    int vectors = 0;
    int errs    = 0;

    // input history seen at each clock edge; edges up to rst_cyc read as 0
    logic slow_h [MAXC];
    logic run_h  [MAXC];
    logic btn_h  [MAXC];
    int   cyc     = 0;
    int   rst_cyc = 0;

    int   m_mode;
    logic m_db;
    int   m_dbrun;
    logic m_rise;
    logic m_en;
    int   m_count;

    function automatic logic hist(input int sel, input int j);
        if (j <= rst_cyc || j < 0) return 1'b0;
        case (sel)
            0:       return slow_h[j];
            1:       return run_h[j];
            default: return btn_h[j];
        endcase
    endfunction

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_db    = 1'b0;
        m_dbrun = 0;
        m_rise  = 1'b0;
        m_en    = 1'b0;
        m_count = 0;
    endtask

    // behaviour at edge k: slowClk rise reaches the FSM 3 edges later,
    // runSw and the button 2 edges later, the press pulse one edge after debounce
    task automatic model_edge(input int k, input logic h);
        logic tk;
        logic rs;
        logic req;
        logic b;
        logic en;
        tk  = hist(0, k - 3) & ~hist(0, k - 4);
        rs  = hist(1, k - 2);
        b   = hist(2, k - 2);
        req = m_rise;
        m_rise = 1'b0;
        if (b != m_db) begin
            m_dbrun++;
            if (m_dbrun == C) begin
                m_db    = b;
                m_dbrun = 0;
                m_rise  = b;
            end
        end else begin
            m_dbrun = 0;
        end
        en = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (h)        m_mode = M_HALT;
                else if (rs)  m_mode = M_RUN;
                else if (req) m_mode = M_ARM;
            end
            M_RUN: begin
                if (h)        m_mode = M_HALT;
                else if (!rs) m_mode = M_IDLE;
                else if (tk)  en = 1'b1;
            end
            M_ARM: begin
                if (h) begin
                    m_mode = M_HALT;
                end else if (tk) begin
                    en     = 1'b1;
                    m_mode = M_IDLE;
                end
            end
            default: begin
                if (!rs && req) m_mode = M_IDLE;
            end
        endcase
        m_en    = en;
        m_count = (m_count + int'(en)) % (1 << SW);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @%0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    logic prev_en = 1'b0;

    // called at a negedge with inputs already set; returns at the next negedge
    task automatic step_cycle();
        logic h;
        h = haltReq;
        if (cyc < MAXC) begin
            slow_h[cyc] = slowClk;
            run_h[cyc]  = runSw;
            btn_h[cyc]  = stepBtn;
        end
        @(posedge clkIn);
        if (rst) begin
            rst_cyc = cyc;
            model_reset();
        end else begin
            model_edge(cyc, h);
        end
        cyc++;
        @(negedge clkIn);
        chk("cycle", {25'd0, stepEn, running, halted, stepCount},
            {25'd0, m_en, logic'(m_mode == M_RUN),
             logic'(m_mode == M_HALT), SW'(m_count)});
        chk("no_back2back", 32'(prev_en & stepEn), 32'd0);
        prev_en = stepEn;
    endtask

    function automatic logic btn_pat(input int press, input int c);
        case (press)
            1:       return (c < 3) ? (c != 1) : (c < 13);
            2:       return (c < 5) || (c >= 11 && c < 16);
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_phase(input logic r, input logic h, input int press,
                             input int periods, output int pulses);
        pulses = 0;
        for (int c = 0; c < periods * PER; c++) begin
            runSw   = r;
            haltReq = h;
            slowClk = (c % PER) < PER / 2;
            stepBtn = btn_pat(press, c);
            step_cycle();
            if (stepEn) pulses++;
        end
        haltReq = 1'b0;
    endtask

    typedef struct {
        string nm;
        logic  r;
        logic  h;
        int    press;
        int    periods;
        int    pulses;
        logic  run_o;
        logic  halt_o;
    } phase_t;

    phase_t tbl [7];

    initial begin
        int p;
        int exp_cnt;
        int hs;
        int hcnt;

        tbl[0] = '{"run5",      1'b1, 1'b0, 0,  5,  5, 1'b1, 1'b0};
        tbl[1] = '{"step",      1'b0, 1'b0, 1,  2,  1, 1'b0, 1'b0};
        tbl[2] = '{"halt_idle", 1'b1, 1'b1, 0,  2,  0, 1'b0, 1'b1};
        tbl[3] = '{"halt_hold", 1'b1, 1'b0, 0,  2,  0, 1'b0, 1'b1};
        tbl[4] = '{"halt_ack",  1'b0, 1'b0, 1,  2,  0, 1'b0, 1'b0};
        tbl[5] = '{"armed2",    1'b0, 1'b0, 2,  2,  1, 1'b0, 1'b0};
        tbl[6] = '{"wrap17",    1'b1, 1'b0, 0, 17, 17, 1'b1, 1'b0};

        model_reset();
        @(negedge clkIn);
        chk("reset_state", {28'd0, stepEn, running, halted, |stepCount}, 32'd0);
        for (int i = 0; i < 3; i++) step_cycle();
        rst = 1'b0;

        exp_cnt = 0;
        foreach (tbl[i]) begin
            run_phase(tbl[i].r, tbl[i].h, tbl[i].press, tbl[i].periods, p);
            exp_cnt = (exp_cnt + tbl[i].pulses) % (1 << SW);
            chk({tbl[i].nm, "_pulses"}, 32'(p), 32'(tbl[i].pulses));
            chk({tbl[i].nm, "_mode"}, {30'd0, running, halted},
                {30'd0, tbl[i].run_o, tbl[i].halt_o});
            chk({tbl[i].nm, "_count"}, 32'(stepCount), 32'(exp_cnt));
        end

        // haltReq coincides with the tick seen by the FSM in RUN
        for (int c = 0; c < PER; c++) begin
            runSw   = 1'b1;
            slowClk = c < PER / 2;
            haltReq = (c == 3);
            step_cycle();
            if (c == 3) begin
                chk("halt_tick_en", 32'(stepEn), 32'd0);
                chk("halt_tick_halted", 32'(halted), 32'd1);
            end
        end
        haltReq = 1'b0;
        run_phase(1'b1, 1'b0, 0, 2, p);
        chk("halt_ignore_ticks", 32'(p), 32'd0);
        chk("halt_count_frozen", 32'(stepCount), 32'(exp_cnt));
        run_phase(1'b0, 1'b0, 1, 1, p);
        chk("halt_release", {30'd0, running, halted}, 32'd0);

        // async reset while stepEn is high
        run_phase(1'b1, 1'b0, 0, 1, p);
        for (int c = 0; c < 4; c++) begin
            runSw   = 1'b1;
            slowClk = c < PER / 2;
            step_cycle();
        end
        chk("pre_reset_en", 32'(stepEn), 32'd1);
        rst = 1'b1;
        rst_cyc = cyc - 1;
        model_reset();
        #1;
        chk("async_clear", {28'd0, stepEn, running, halted, |stepCount}, 32'd0);
        runSw   = 1'b0;
        slowClk = 1'b0;
        @(negedge clkIn);
        for (int i = 0; i < 2; i++) step_cycle();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step_cycle();
        chk("post_reset_idle", {30'd0, running, halted}, 32'd0);

        // random stimulus against the model
        hs   = 5;
        hcnt = 0;
        for (int i = 0; i < 4000; i++) begin
            if (++hcnt >= hs) begin
                hcnt    = 0;
                hs      = $urandom_range(2, 12);
                slowClk = ~slowClk;
            end
            if ($urandom_range(0, 149) == 0) runSw = ~runSw;
            if ($urandom_range(0, 7) == 0) stepBtn = ~stepBtn;
            haltReq = ($urandom_range(0, 99) == 0);
            step_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
